// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - parametrised multi-stage pipeline register chain with valid/ready, stall and selective flush
//
// Purpose:
//   Moves a WIDTH-bit payload through STAGES register slots. Each slot has its
//   own valid bit. Empty slots collapse forward under backpressure. A global
//   stall freezes the chain. A masked flush kills individual slots. Empty or
//   killed slots always hold BUBBLE_PAYLOAD.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, adds saturating stall/bubble counters that perf_clr can clear.
//   When undefined, stall_cnt and bubble_cnt read as zero.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   reset      - asynchronous, active-high; clears all state
//   in_valid   - upstream payload present
//   in_data    - upstream payload
//   in_ready   - slot 0 can take a payload this cycle
//   out_valid  - last slot holds a live payload
//   out_data   - payload of the last slot
//   out_ready  - downstream accepts this cycle
//   stall      - global hold
//   flush      - kill request, qualified by flush_mask
//   flush_mask - bit i kills slot i when flush is high
//   occupancy  - registered count of valid slots
//   perf_clr   - synchronous clear of the perf counters
//   stall_cnt  - cycles with stall high
//   bubble_cnt - cycles with no output and no stall

module pipe_reg_chain #(
  parameter int          WIDTH          = 32,
  parameter int          STAGES         = 1,
  parameter logic [31:0] BUBBLE_PAYLOAD = 32'h00000013
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [STAGES-1:0]             flush_mask,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  input  logic                          perf_clr,
  output logic [31:0]                   stall_cnt,
  output logic [31:0]                   bubble_cnt
);

  localparam int               OCC_W  = $clog2(STAGES + 1);
  localparam logic [WIDTH-1:0] BUBBLE = WIDTH'(BUBBLE_PAYLOAD);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [OCC_W-1:0]  r_occupancy;

  logic [STAGES-1:0] w_can_move;
  logic [STAGES-1:0] w_valid_nxt;
  logic [WIDTH-1:0]  w_data_nxt [STAGES];
  logic [OCC_W-1:0]  w_occ_nxt;
  logic              w_accept;

  // A slot can move when it is empty or everything downstream of it can move.
  // The chain is walked from the output side with a running term so that no
  // bit of w_can_move is read back inside the block that writes it.
  always_comb begin
    logic w_carry;
    w_carry    = out_ready;
    w_can_move = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_carry       = ~r_valid[i] | w_carry;
      w_can_move[i] = w_carry;
    end
  end

  assign in_ready  = ~reset & ~stall & ~flush & w_can_move[0];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_valid[STAGES-1] & ~stall & ~(flush & flush_mask[STAGES-1]);
  assign out_data  = r_data[STAGES-1];
  assign occupancy = r_occupancy;

  // Next-state of the slot array. Flush takes precedence over stall; both
  // block any advance. Invalid slots always carry BUBBLE, so a moving slot
  // can copy its upstream neighbour's data without looking at its valid bit.
  always_comb begin
    w_valid_nxt = r_valid;
    for (int i = 0; i < STAGES; i++) begin
      w_data_nxt[i] = r_data[i];
    end

    if (flush) begin
      for (int i = 0; i < STAGES; i++) begin
        if (flush_mask[i]) begin
          w_valid_nxt[i] = 1'b0;
          w_data_nxt[i]  = BUBBLE;
        end
      end
    end else if (!stall) begin
      if (w_can_move[0]) begin
        w_valid_nxt[0] = w_accept;
        w_data_nxt[0]  = w_accept ? in_data : BUBBLE;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (w_can_move[i]) begin
          w_valid_nxt[i] = r_valid[i-1];
          w_data_nxt[i]  = r_data[i-1];
        end
      end
    end
  end

  // Occupancy is registered alongside the valid bits, so it is the popcount
  // of the next valid vector.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_occupancy <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= BUBBLE;
      end
    end else begin
      r_valid     <= w_valid_nxt;
      r_occupancy <= w_occ_nxt;
      for (int i = 0; i < STAGES; i++) begin
        r_data[i] <= w_data_nxt[i];
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Both counters saturate at all-ones. A clear in the same cycle as an
  // increment leaves the counter at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (perf_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != 32'hFFFFFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!out_valid && !stall && (r_bubble_cnt != 32'hFFFFFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  logic w_unused_perf_clr;

  assign w_unused_perf_clr = perf_clr;
  assign stall_cnt         = 32'h0;
  assign bubble_cnt        = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain (STAGES=3, WIDTH=32)

module tb_pipe_reg_chain;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready = 1'b0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic [STAGES-1:0] flush_mask = '0;
  logic [1:0]        occupancy;
  logic              perf_clr = 1'b0;
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] exp_d;

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .STAGES(STAGES),
    .BUBBLE_PAYLOAD(NOP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .stall(stall),
    .flush(flush),
    .flush_mask(flush_mask),
    .occupancy(occupancy),
    .perf_clr(perf_clr),
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Scoreboard: accepted payloads are queued; every output transfer must
  // match the oldest queued payload. Sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got out_data %0h with nothing expected", out_data);
        end else begin
          exp_d = sb.pop_front();
          if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_data: got %0h expected %0h", out_data, exp_d);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
    n_checks++; if (out_data !== NOP) begin n_fail++; $display("FAIL rst_out_data: got %0h expected %0h", out_data, NOP); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_high: got %0b expected 0", in_ready); end
    n_checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_counters: got %0h/%0h expected 0/0", stall_cnt, bubble_cnt); end
    tick;
    tick;
    reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_low: got %0b expected 1", in_ready); end
  endtask

  task automatic test_stream;
    int peak;
    peak = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 * (k + 1);
      tick;
      if (int'(occupancy) > peak) peak = int'(occupancy);
      n_checks++; if (out_valid !== (k == 2)) begin n_fail++; $display("FAIL stream_latency_%0d: got out_valid %0b expected %0b", k, out_valid, (k == 2)); end
      n_checks++; if (out_data !== ((k == 2) ? 32'h11 : NOP)) begin n_fail++; $display("FAIL stream_data_%0d: got %0h expected %0h", k, out_data, ((k == 2) ? 32'h11 : NOP)); end
    end
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    n_checks++; if (peak != 3) begin n_fail++; $display("FAIL stream_peak_occ: got %0d expected 3", peak); end
    n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: got occ %0d valid %0b expected 0 0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA1 + k;
      tick;
    end
    in_data = 32'hA4;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %0b expected 0", in_ready); end
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL bp_full_occ: got %0d expected 3", occupancy); end
    n_checks++; if (out_data !== 32'hA1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_out: got %0h/%0b expected a1/1", out_data, out_valid); end
    tick;
    tick;
    n_checks++; if (out_data !== 32'hA1 || occupancy !== 2'd3) begin n_fail++; $display("FAIL bp_stable: got %0h occ %0d expected a1 occ 3", out_data, occupancy); end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b expected 1", in_ready); end
    tick;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    n_checks++; if (occupancy !== 2'd3 || out_data !== 32'hA2) begin n_fail++; $display("FAIL bp_after_one: got occ %0d data %0h expected 3 a2", occupancy, out_data); end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick;
    n_checks++; if (occupancy !== 2'd0 || sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got occ %0d sb %0d expected 0 0", occupancy, sb.size()); end
  endtask

  task automatic test_bubble_collapse;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    n_checks++; if (out_data !== 32'hB1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bc_head: got %0h/%0b expected b1/1", out_data, out_valid); end
    in_valid = 1'b1;
    in_data  = 32'hB2;
    tick;
    in_valid = 1'b0;
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bc_gap_occ: got %0d expected 2", occupancy); end
    tick;
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bc_collapsed: got occ %0d in_ready %0b expected 2 1", occupancy, in_ready); end
    out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 32'hB2 || occupancy !== 2'd1) begin n_fail++; $display("FAIL bc_next_out: got %0b/%0h occ %0d expected 1/b2 occ 1", out_valid, out_data, occupancy); end
    tick;
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL bc_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hC1 + k;
      tick;
    end
    flush      = 1'b1;
    flush_mask = 3'b011;
    in_data    = 32'hC4;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_during: got in_ready %0b out_valid %0b expected 0 1", in_ready, out_valid); end
    tick;
    flush      = 1'b0;
    flush_mask = 3'b000;
    in_valid   = 1'b0;
    while (sb.size() > 1) void'(sb.pop_back());
    #1;
    n_checks++; if (occupancy !== 2'd1 || out_data !== 32'hC1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_011: got occ %0d %0h/%0b expected 1 c1/1", occupancy, out_data, out_valid); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC5;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_000_in_ready: got %0b expected 0", in_ready); end
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++; if (occupancy !== 2'd1 || out_data !== 32'hC1) begin n_fail++; $display("FAIL fl_000_frozen: got occ %0d data %0h expected 1 c1", occupancy, out_data); end
    flush      = 1'b1;
    flush_mask = 3'b100;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_100_out_valid: got %0b expected 0", out_valid); end
    tick;
    flush      = 1'b0;
    flush_mask = 3'b000;
    void'(sb.pop_front());
    #1;
    n_checks++; if (occupancy !== 2'd0 || out_data !== NOP || out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_100_after: got occ %0d %0h/%0b expected 0 13/0", occupancy, out_data, out_valid); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    perf_clr = 1'b1;
    tick;
    perf_clr  = 1'b0;
    stall     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hD2;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL st_hold_%0d: got in_ready %0b out_valid %0b expected 0 0", k, in_ready, out_valid); end
      tick;
    end
    stall     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (occupancy !== 2'd1 || out_data !== 32'hD1) begin n_fail++; $display("FAIL st_after: got occ %0d data %0h expected 1 d1", occupancy, out_data); end
`ifdef PIPE_PERF_CNT_EN
    n_checks++; if (stall_cnt !== 32'd4 || bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL st_counters: got %0d/%0d expected 4/0", stall_cnt, bubble_cnt); end
`else
    n_checks++; if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL st_counters_off: got %0d/%0d expected 0/0", stall_cnt, bubble_cnt); end
`endif
    out_ready = 1'b1;
    tick;
    tick;
`ifdef PIPE_PERF_CNT_EN
    n_checks++; if (bubble_cnt !== 32'd1 || stall_cnt !== 32'd4) begin n_fail++; $display("FAIL st_bubble_cnt: got %0d/%0d expected 4/1", stall_cnt, bubble_cnt); end
`else
    n_checks++; if (bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL st_bubble_off: got %0d expected 0", bubble_cnt); end
`endif
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL st_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      tick;
    end
    in_valid  = 1'b0;
    stall     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick;
    n_checks++; if (sb.size() != 0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL b2b_drain: got sb %0d occ %0d expected 0 0", sb.size(), occupancy); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hE1;
    tick;
    in_data = 32'hE2;
    tick;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    sb.delete();
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== NOP) begin n_fail++; $display("FAIL mr_out: got %0b/%0h expected 0/13", out_valid, out_data); end
    n_checks++; if (occupancy !== 2'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mr_state: got occ %0d in_ready %0b expected 0 0", occupancy, in_ready); end
    tick;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_release: got in_ready %0b out_valid %0b expected 1 0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble_collapse();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_reg_chain.md
Name: pipe_reg_chain

Overview:
Parametrised multi-stage pipeline register for the RV32IC core, successor to the fixed single-stage IF/ID and ID/EX registers. Carries a WIDTH-bit payload through STAGES register slots with per-slot valid bits, valid/ready backpressure with bubble collapsing, a global stall, and per-slot selective flush for jumps and branches. Instantiated between fetch/decode/execute; one instance per pipeline boundary, or one deep instance for a multi-cycle path.

Parameters:
WIDTH, 32, payload width in bits (1..256)
STAGES, 1, number of register slots (1..8); slot 0 is input side, slot STAGES-1 drives output
BUBBLE_PAYLOAD, 32'h00000013, data value loaded into emptied/flushed slots (RV32 NOP, addi x0,x0,0); zero-extended or truncated to WIDTH

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
in_valid  in  1  upstream has payload
in_data  in  WIDTH  upstream payload
in_ready  out  1  slot 0 can take payload this cycle
out_valid  out  1  slot STAGES-1 holds live payload
out_data  out  WIDTH  payload of slot STAGES-1
out_ready  in  1  downstream accepts this cycle
stall  in  1  global hold (hazard unit)
flush  in  1  kill request
flush_mask  in  STAGES  slots killed when flush=1 (bit i = slot i)
occupancy  out  $clog2(STAGES+1)  number of valid slots, registered
perf_clr  in  1  synchronous clear of perf counters (optional feature)
stall_cnt  out  32  stall cycle count (optional feature)
bubble_cnt  out  32  empty-output cycle count (optional feature)

Behaviour:
- Reset (async assert, any time incl. mid-transfer): all valid bits 0, all slot data = BUBBLE_PAYLOAD, occupancy 0, counters 0. Outputs: out_valid 0, out_data BUBBLE_PAYLOAD, in_ready 1 after reset deasserts (0 while reset high).
- Priority per edge: reset > flush > stall > normal advance.
- Slot i "can_move": slot i empty, or slot i+1 can_move (i<STAGES-1), or out_ready (i=STAGES-1). Combinational chain, no registered ready.
- Normal advance (stall=0, flush=0): every slot with can_move takes contents of slot i-1 (slot 0 takes in_data when in_valid&in_ready); a slot that moves out and receives nothing becomes invalid with data = BUBBLE_PAYLOAD. Bubbles collapse: a full chain with a gap fills the gap while output is blocked.
- Throughput 1 item/cycle; latency exactly STAGES cycles from accept edge to out_valid with out_ready held 1.
- in_ready = ~reset & ~stall & ~flush & can_move(0).
- out_valid = valid[STAGES-1] & ~stall & ~(flush & flush_mask[STAGES-1]). Transfer out occurs only when out_valid & out_ready.
- stall=1, flush=0: no slot changes, no transfer in or out, occupancy constant.
- flush=1: slots with mask bit 1 cleared (valid 0, data BUBBLE_PAYLOAD) at edge; unmasked slots hold (even if stall=0, no advance this cycle); input not accepted. flush with stall: identical.
- flush_mask all zero with flush=1: pipeline frozen one cycle, no change.
- occupancy updated same edge as valid bits; equals popcount of valid vector after the edge.
- STAGES=1 degenerates to single register with valid/ready; must be legal.

Optional Feature:
PIPE_PERF_CNT_EN. Defined: stall_cnt increments each cycle stall=1; bubble_cnt increments each cycle out_valid=0 and stall=0; both saturate at 32'hFFFFFFFF; perf_clr=1 zeroes both at the edge (clear wins over increment). Undefined: ports present, both tied to 32'h0, perf_clr ignored, no counter flops.

Test Plan:
- STAGES=3, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 3,4,5 after first accept; occupancy peaks 3.
- STAGES=3 full, out_ready=0 -> in_ready=0, occupancy 3, data stable; out_ready=1 one cycle -> one item leaves, in_ready=1 same cycle, new item accepted.
- Chain with valid pattern 1,0,1 (slot0..2), out_ready=0 -> after one edge slots 1,2 valid, slot 0 empty (bubble collapsed), occupancy 2.
- STAGES=3 full, flush=1, flush_mask=3'b011 -> slots 0,1 become BUBBLE_PAYLOAD 0x00000013 invalid, slot 2 holds, occupancy 1, in_ready 0 that cycle.
- stall=1 for 4 cycles with in_valid=1, out_ready=1 -> no accepts, no out transfers; with PIPE_PERF_CNT_EN stall_cnt=4, bubble_cnt unchanged.
- Assert reset mid-stream between edges -> out_valid drops immediately, out_data=0x00000013, occupancy 0; deassert -> in_ready=1 next cycle.
